// File: rtl/cuenta_pkg.sv
// cuenta_pkg: shared FSM state type, mode constants and clog2 helper for the popcount unit.
package cuenta_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } estado_t;

    localparam logic MODO_UNOS  = 1'b0;
    localparam logic MODO_CEROS = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cuenta_bloque.sv
// cuenta_bloque: combinational popcount of a BPC-bit slice.
//   i_bits : BPC-bit slice to count
//   o_cnt  : number of ones in i_bits, clog2(BPC+1) bits wide
module cuenta_bloque
    import cuenta_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0]              i_bits,
    output logic [clog2(BPC+1)-1:0]     o_cnt
);

    localparam int PW = clog2(BPC + 1);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < BPC; i++)
            o_cnt = o_cnt + PW'(i_bits[i]);
    end

endmodule

// File: rtl/cuenta_unos_param.sv
// cuenta_unos_param: multi-cycle population counter (ones or zeros) with start/fin handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : begin a count (accepted in IDLE or DONE only)
//   modo         : 0 = count ones, 1 = count zeros; captured with entrada
//   entrada      : WIDTH-bit word captured on an accepted start
//   salida       : registered count, holds until the next result
//   fin          : result valid, high in DONE only
//   ocupado      : high while counting
module cuenta_unos_param
    import cuenta_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           modo,
    input  logic [WIDTH-1:0]               entrada,
    output logic [clog2(WIDTH+1)-1:0]      salida,
    output logic                           fin,
    output logic                           ocupado
);

    localparam int CW = clog2(WIDTH + 1);
    localparam int PW = clog2(BPC + 1);
    localparam int N  = WIDTH / BPC;
    localparam int NW = clog2(N + 1);

    if ((WIDTH % BPC) != 0 || WIDTH < 2) begin : g_param_err
        $error("cuenta_unos_param: WIDTH must be >= 2 and a multiple of BPC");
    end

    estado_t          r_estado;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_acc;
    logic [NW-1:0]    r_chunk;
    logic [CW-1:0]    r_salida;
    logic             r_fin;
    logic             r_ocupado;
    logic [PW-1:0]    w_pop;
    logic [CW-1:0]    w_suma;
    logic             w_ultimo;

    cuenta_bloque #(.BPC(BPC)) u_bloque (
        .i_bits (r_shift[BPC-1:0]),
        .o_cnt  (w_pop)
    );

    // Zero-extension is safe: a BPC-bit popcount never exceeds the WIDTH range of CW.
    assign w_suma   = r_acc + CW'(w_pop);
    assign w_ultimo = r_chunk == NW'(N - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_estado  <= IDLE;
            r_shift   <= '0;
            r_acc     <= '0;
            r_chunk   <= '0;
            r_salida  <= '0;
            r_fin     <= 1'b0;
            r_ocupado <= 1'b0;
        end else if (r_estado == COUNT) begin
            r_acc   <= w_suma;
            r_shift <= r_shift >> BPC;
            r_chunk <= r_chunk + NW'(1);
            if (w_ultimo) begin
                r_salida  <= w_suma;
                r_fin     <= 1'b1;
                r_ocupado <= 1'b0;
                r_estado  <= DONE;
            end
        end else if (start) begin
            // Zeros mode counts ones of the inverted word, so one datapath serves both modes.
            r_shift   <= modo == MODO_CEROS ? ~entrada : entrada;
            r_acc     <= '0;
            r_chunk   <= '0;
            r_fin     <= 1'b0;
            r_ocupado <= 1'b1;
            r_estado  <= COUNT;
        end
    end

    assign salida  = r_salida;
    assign fin     = r_fin;
    assign ocupado = r_ocupado;

endmodule

// File: tb/tb_cuenta_unos_param.sv
// tb_cuenta_unos_param: scoreboard bench for an 8/1 and a 16/4 instance of cuenta_unos_param.
module tb_cuenta_unos_param;

    typedef struct {
        int val;
        int acc;
    } exp_t;

    localparam int NN[2] = '{8, 4};
    localparam int WW[2] = '{8, 16};

    logic        clk;
    logic        reset_n;
    logic        start[2];
    logic        modo[2];
    logic [15:0] ent[2];
    logic        fin[2];
    logic        ocu[2];
    logic [3:0]  salida0;
    logic [4:0]  salida1;
    int          sal[2];
    int          cyc;
    int          checks;
    int          passed;
    exp_t        q0[$];
    exp_t        q1[$];
    logic        fin_q[2];
    int          hold[2];

    cuenta_unos_param #(.WIDTH(8), .BPC(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .modo(modo[0]),
        .entrada(ent[0][7:0]), .salida(salida0), .fin(fin[0]), .ocupado(ocu[0])
    );

    cuenta_unos_param #(.WIDTH(16), .BPC(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .modo(modo[1]),
        .entrada(ent[1]), .salida(salida1), .fin(fin[1]), .ocupado(ocu[1])
    );

    assign sal[0] = int'(salida0);
    assign sal[1] = int'(salida1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int model(input int i, input logic [15:0] w, input logic m);
        int n;
        n = $countones(i == 0 ? (w & 16'h00FF) : w);
        return m ? WW[i] - n : n;
    endfunction

    task automatic push(input int i, input int v, input int a);
        exp_t e;
        e.val = v;
        e.acc = a;
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Monitor: pops an expectation on every rising fin and checks value, latency and hold.
    always @(negedge clk) begin
        if (!reset_n) begin
            fin_q[0] <= 1'b0;
            fin_q[1] <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                bit   have;
                chk(!(fin[i] && ocu[i]), $sformatf("excl%0d", i), int'(fin[i] && ocu[i]), 0);
                if (fin[i] && !fin_q[i]) begin
                    have = i == 0 ? q0.size() > 0 : q1.size() > 0;
                    if (have) begin
                        e = i == 0 ? q0.pop_front() : q1.pop_front();
                        chk(sal[i] == e.val, $sformatf("salida%0d", i), sal[i], e.val);
                        chk(cyc - e.acc == NN[i], $sformatf("latency%0d", i), cyc - e.acc, NN[i]);
                    end else begin
                        chk(1'b0, $sformatf("unexpected_fin%0d", i), 1, 0);
                    end
                end else if (fin[i] && fin_q[i]) begin
                    chk(sal[i] == hold[i], $sformatf("hold%0d", i), sal[i], hold[i]);
                end
                hold[i]  <= sal[i];
                fin_q[i] <= fin[i];
            end
        end
    end

    task automatic op(input int i, input logic [15:0] w, input logic m, input int gap);
        int acc;
        bit ok;
        repeat (gap) @(negedge clk);
        start[i] = 1'b1;
        ent[i]   = w;
        modo[i]  = m;
        acc      = cyc + 1;
        push(i, model(i, w, m), acc);
        @(negedge clk);
        start[i] = 1'b0;
        ent[i]   = 16'($urandom);
        modo[i]  = 1'($urandom);
        ok = 1'b1;
        while (cyc < acc + NN[i]) begin
            if (!ocu[i]) ok = 1'b0;
            @(negedge clk);
        end
        chk(ok, $sformatf("busy%0d", i), int'(ok), 1);
    endtask

    initial begin
        int  acc;
        bit  ok;
        cyc     = 0;
        checks  = 0;
        passed  = 0;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            modo[i]  = 1'b0;
            ent[i]   = '0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(sal[i] == 0, "rst_salida", sal[i], 0);
            chk(fin[i] == 1'b0, "rst_fin", int'(fin[i]), 0);
            chk(ocu[i] == 1'b0, "rst_ocupado", int'(ocu[i]), 0);
        end

        op(0, 16'h00B5, 1'b0, 0);
        op(0, 16'h00B5, 1'b1, 2);
        op(0, 16'h00FF, 1'b0, 1);
        op(0, 16'h0000, 1'b1, 0);
        repeat (2) @(negedge clk);

        // Start held high across COUNT and into DONE; entrada changes mid-count.
        start[0] = 1'b1;
        ent[0]   = 16'h00F0;
        modo[0]  = 1'b0;
        acc      = cyc + 1;
        push(0, 4, acc);
        @(negedge clk);
        ent[0] = 16'h0000;
        while (cyc < acc + NN[0]) @(negedge clk);
        chk(fin[0] == 1'b1, "fin_before_restart", int'(fin[0]), 1);
        acc = cyc + 1;
        push(0, 0, acc);
        @(negedge clk);
        chk(fin[0] == 1'b0, "restart_fin_drop", int'(fin[0]), 0);
        chk(ocu[0] == 1'b1, "restart_busy", int'(ocu[0]), 1);
        start[0] = 1'b0;
        while (cyc < acc + NN[0]) @(negedge clk);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a count.
        start[0] = 1'b1;
        ent[0]   = 16'h00FF;
        modo[0]  = 1'b0;
        acc      = cyc + 1;
        @(negedge clk);
        start[0] = 1'b0;
        while (cyc < acc + 3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk(sal[0] == 0, "async_salida", sal[0], 0);
        chk(fin[0] == 1'b0, "async_fin", int'(fin[0]), 0);
        chk(ocu[0] == 1'b0, "async_ocupado", int'(ocu[0]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        ok = 1'b1;
        repeat (2 * NN[0]) begin
            @(negedge clk);
            if (fin[0] || ocu[0]) ok = 1'b0;
        end
        chk(ok, "idle_after_reset", int'(ok), 1);

        op(1, 16'hA5F0, 1'b0, 1);
        op(1, 16'hFFFF, 1'b0, 0);

        for (int k = 0; k < 25; k++) begin
            op(0, 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
            op(1, 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        chk(q0.size() == 0, "q0_drained", q0.size(), 0);
        chk(q1.size() == 0, "q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cuenta_unos_param.md
Name: cuenta_unos_param

Overview:
- Parametrised, multi-cycle population counter with a start/fin handshake.
- On `start` it captures a WIDTH-bit word, then counts the 1s (or 0s, selected by `modo`) over WIDTH/BPC cycles, processing BPC bits per cycle.
- It presents the count on `salida` and holds `fin` high until the next start.
- It is the general successor of the fixed 3-bit ones counter and is used as a reusable bit-statistics unit in the datapath.

Parameters:
- WIDTH, 8, input word width; must be ≥ 2.
- BPC, 1, bits processed per clock; must divide WIDTH exactly (elaboration-time error otherwise).
- CW, clog2(WIDTH+1), derived local parameter, not overridable: width of `salida`.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a count; level-sampled on the rising edge.
- modo  in  1  0 = count ones, 1 = count zeros; captured together with `entrada`.
- entrada  in  WIDTH  word to count; captured on an accepted start.
- salida  out  CW  result count; registered.
- fin  out  1  result valid; registered level.
- ocupado  out  1  high while counting; registered.

Behaviour:
- Reset (reset_n=0, asynchronous): state = IDLE; `salida`=0, `fin`=0, `ocupado`=0; the internal shift register, accumulator and chunk counter are cleared. Reset asserted mid-count aborts the operation immediately; no partial result is ever shown.
- States: IDLE, COUNT, DONE. Let N = WIDTH/BPC.
- IDLE:
  - start=1 at edge k → capture `entrada` (inverted if `modo`=1) into the shift register, accumulator=0, chunk counter=0, `ocupado`=1, state = COUNT.
  - start=0 → stay in IDLE.
- COUNT:
  - Each edge adds the popcount of the low BPC bits of the shift register to the accumulator, shifts right by BPC and increments the chunk counter.
  - On the N-th COUNT edge (edge k+N): `salida` ← accumulator + final chunk, `fin`=1, `ocupado`=0, state = DONE.
  - `start`, `modo` and `entrada` are ignored throughout COUNT; a start is neither queued nor restarts the count.
- DONE:
  - `salida` and `fin` hold.
  - start=1 at an edge → `fin`=0 on that same edge, new capture as in IDLE, state = COUNT. Back-to-back operation is therefore one start per N+1 cycles.
  - `salida` keeps its old value until the new result is written.
- Latency: `fin` rises N rising edges after the edge that accepted start. Examples: WIDTH=8, BPC=1 → 8 cycles; WIDTH=8, BPC=8 → 1 cycle.
- Arithmetic: the accumulator is CW bits wide. The maximum result, WIDTH, fits without overflow, so no saturation is needed.
- Zeros mode is implemented as a ones-count of the inverted captured word. The result for an all-zero word in zeros mode is WIDTH.
- `ocupado` and `fin` are never high simultaneously. `fin` is low whenever state ≠ DONE.

Decomposition:
- Shared package `cuenta_pkg`:
  - state typedef (IDLE=2'd0, COUNT=2'd1, DONE=2'd2);
  - clog2 constant function;
  - MODO_UNOS=1'b0 and MODO_CEROS=1'b1 constants.
- One sub-module, `cuenta_bloque`: combinational popcount of a BPC-bit slice producing a clog2(BPC+1)-bit result. It is instantiated once in the top level.
- The FSM, shift register and accumulator stay in `cuenta_unos_param`.

Test Plan:
- WIDTH=8, BPC=1: reset_n low for 2 cycles, then release → `salida`=0, `fin`=0, `ocupado`=0. Then entrada=8'b1011_0101, modo=0, start pulsed one cycle → `ocupado`=1 for 8 cycles, then `fin`=1 and `salida`=5, holding until the next start.
- Same word, modo=1 → `salida`=3. Then entrada=8'hFF, modo=0 → `salida`=8. Then entrada=8'h00, modo=1 → `salida`=8, exercising the full CW=4 range.
- Mid-count disturbance: start held high and entrada changed to 8'h00 during COUNT after capturing 8'hF0 → result is still 4, with `fin` exactly 8 edges after acceptance. Start still high in DONE → an immediate restart with `fin` dropping on that edge.
- Mid-count reset: reset_n pulsed low at cycle 4 of a count → all outputs are 0 asynchronously. After release the block stays in IDLE and `fin` never rises until a new start.
- Wider, faster configuration: WIDTH=16, BPC=4, entrada=16'hA5F0, modo=0 → `fin` after 4 cycles with `salida`=8. Then a back-to-back start in DONE with 16'hFFFF → `salida`=16 after 4 more cycles.
